// File: rtl/timer_prescaler.sv
// Shared 10-bit prescaler with per-timer clock select and synchronized
// external-pin edge detection; PSR/TSTAT registers on the I/O bus.
module timer_prescaler #(
  parameter logic [5:0] base_addr = 6'h15
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [5:0] io_a,
  input  logic       io_we,
  input  logic       io_re,
  input  logic [7:0] io_di,
  output logic [7:0] io_do,
  input  logic       t0_pin,
  input  logic       t1_pin,
  input  logic [2:0] clk_sel0,
  input  logic [2:0] clk_sel1,
  output logic       timer0_clk,
  output logic       timer1_clk
);

  localparam logic [5:0] stat_addr = base_addr + 6'd1;

  logic [9:0] pre_cnt;
  logic       tsm;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] prev;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       psr_hit;
  logic       stat_hit;
  logic       psr_wr;
  logic [3:0] taps;
  logic       unused_di;

  assign psr_hit   = (io_a == base_addr);
  assign stat_hit  = (io_a == stat_addr);
  assign psr_wr    = io_we & psr_hit;
  assign unused_di = ^io_di[7:2];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pre_cnt <= '0;
      tsm     <= 1'b0;
    end else begin
      if (psr_wr)
        tsm <= io_di[1];
      if ((psr_wr && io_di[0]) || tsm)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + 10'd1;
    end
  end

  // Edge pulses are registered so a pin change reaches the timer on the third edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      sync1 <= {t1_pin, t0_pin};
      sync2 <= sync1;
      prev  <= sync2;
      rise  <= ~prev & sync2;
      fall  <= prev & ~sync2;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      io_do <= '0;
    else if (io_re && psr_hit)
      io_do <= {6'b0, tsm, 1'b0};
    else if (io_re && stat_hit)
      io_do <= {6'b0, sync2};
    else
      io_do <= '0;
  end

  assign taps[0] = ~tsm & (&pre_cnt[2:0]);
  assign taps[1] = ~tsm & (&pre_cnt[5:0]);
  assign taps[2] = ~tsm & (&pre_cnt[7:0]);
  assign taps[3] = ~tsm & (&pre_cnt[9:0]);

  function automatic logic sel_mux(
    input logic [2:0] sel,
    input logic [3:0] tp,
    input logic       r,
    input logic       f
  );
    logic o;
    o = 1'b0;
    case (sel)
      3'd1:    o = 1'b1;
      3'd2:    o = tp[0];
      3'd3:    o = tp[1];
      3'd4:    o = tp[2];
      3'd5:    o = tp[3];
      3'd6:    o = f;
      3'd7:    o = r;
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  always_comb begin
    timer0_clk = sel_mux(clk_sel0, taps, rise[0], fall[0]);
    timer1_clk = sel_mux(clk_sel1, taps, rise[1], fall[1]);
  end

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler: taps, PSR/TSM, ext edges,
// TSTAT reads and asynchronous reset behaviour.
module tb_timer_prescaler;

  localparam logic [5:0] BASE = 6'h15;
  localparam logic [5:0] STAT = 6'h16;

  logic       sys_clk;
  logic       sys_rst;
  logic [5:0] io_a;
  logic       io_we;
  logic       io_re;
  logic [7:0] io_di;
  logic [7:0] io_do;
  logic       t0_pin;
  logic       t1_pin;
  logic [2:0] clk_sel0;
  logic [2:0] clk_sel1;
  logic       timer0_clk;
  logic       timer1_clk;

  int nvec;
  int nerr;

  timer_prescaler #(.base_addr(BASE)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .io_a(io_a),
    .io_we(io_we),
    .io_re(io_re),
    .io_di(io_di),
    .io_do(io_do),
    .t0_pin(t0_pin),
    .t1_pin(t1_pin),
    .clk_sel0(clk_sel0),
    .clk_sel1(clk_sel1),
    .timer0_clk(timer0_clk),
    .timer1_clk(timer1_clk)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic psr_write(input logic [7:0] d);
    io_a  = BASE;
    io_di = d;
    io_we = 1'b1;
    step();
    io_we = 1'b0;
  endtask

  task automatic test_reset();
    int e0;
    int e1;
    sys_rst = 1'b1;
    clk_sel0 = 3'd1;
    clk_sel1 = 3'd2;
    #1;
    nvec++;
    if (timer0_clk !== 1'b1) begin
      nerr++;
      $display("FAIL rst_t0_sel1: got %b want 1", timer0_clk);
    end
    nvec++;
    if (timer1_clk !== 1'b0) begin
      nerr++;
      $display("FAIL rst_t1_sel2: got %b want 0", timer1_clk);
    end
    nvec++;
    if (io_do !== 8'h00) begin
      nerr++;
      $display("FAIL rst_io_do: got %h want 00", io_do);
    end
    step();
    sys_rst = 1'b0;
    e0 = 0;
    e1 = 0;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (timer1_clk !== (j == 7)) e1++;
      if (timer0_clk !== 1'b1) e0++;
    end
    nvec++;
    if (e1 != 0) begin
      nerr++;
      $display("FAIL rst_first_div8: %0d bad cycles want 0", e1);
    end
    nvec++;
    if (e0 != 0) begin
      nerr++;
      $display("FAIL clk1_always: %0d bad cycles want 0", e0);
    end
  endtask

  task automatic test_div();
    int e0;
    int e1;
    int p0;
    int p1;
    clk_sel0 = 3'd2;
    clk_sel1 = 3'd5;
    psr_write(8'h01);
    e0 = 0;
    e1 = 0;
    p0 = 0;
    p1 = 0;
    for (int k = 0; k < 2048; k++) begin
      if (timer0_clk !== ((k % 8) == 7)) e0++;
      if (timer1_clk !== ((k % 1024) == 1023)) e1++;
      if (timer0_clk === 1'b1) p0++;
      if (timer1_clk === 1'b1) p1++;
      step();
    end
    nvec++;
    if (e0 != 0 || p0 != 256) begin
      nerr++;
      $display("FAIL div8: %0d bad, %0d pulses want 256", e0, p0);
    end
    nvec++;
    if (e1 != 0 || p1 != 2) begin
      nerr++;
      $display("FAIL div1024: %0d bad, %0d pulses want 2", e1, p1);
    end
  endtask

  task automatic test_psr_clear();
    int e;
    clk_sel0 = 3'd3;
    repeat (40) step();
    psr_write(8'h01);
    e = 0;
    for (int j = 0; j < 70; j++) begin
      if (timer0_clk !== (j == 63)) e++;
      step();
    end
    nvec++;
    if (e != 0) begin
      nerr++;
      $display("FAIL psr_clear_div64: %0d bad cycles want 0", e);
    end
  endtask

  task automatic test_tsm();
    int e;
    clk_sel0 = 3'd4;
    io_a  = BASE;
    io_di = 8'h03;
    io_we = 1'b1;
    io_re = 1'b1;
    step();
    io_we = 1'b0;
    io_re = 1'b0;
    nvec++;
    if (io_do !== 8'h00) begin
      nerr++;
      $display("FAIL rw_prewrite_0: got %h want 00", io_do);
    end
    e = 0;
    for (int j = 0; j < 500; j++) begin
      if (timer0_clk !== 1'b0) e++;
      step();
    end
    nvec++;
    if (e != 0) begin
      nerr++;
      $display("FAIL tsm_hold: %0d pulses want 0", e);
    end
    io_re = 1'b1;
    step();
    io_re = 1'b0;
    nvec++;
    if (io_do !== 8'h02) begin
      nerr++;
      $display("FAIL psr_read_tsm: got %h want 02", io_do);
    end
    step();
    nvec++;
    if (io_do !== 8'h00) begin
      nerr++;
      $display("FAIL io_do_idle: got %h want 00", io_do);
    end
    io_di = 8'h00;
    io_we = 1'b1;
    io_re = 1'b1;
    step();
    io_we = 1'b0;
    io_re = 1'b0;
    nvec++;
    if (io_do !== 8'h02) begin
      nerr++;
      $display("FAIL rw_prewrite_2: got %h want 02", io_do);
    end
    e = 0;
    for (int j = 0; j < 260; j++) begin
      if (timer0_clk !== (j == 255)) e++;
      step();
    end
    nvec++;
    if (e != 0) begin
      nerr++;
      $display("FAIL tsm_release_div256: %0d bad cycles want 0", e);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    int p;
    clk_sel0 = 3'd2;
    clk_sel1 = 3'd2;
    e = 0;
    p = 0;
    for (int j = 0; j < 64; j++) begin
      if (timer0_clk !== timer1_clk) e++;
      if (timer1_clk === 1'b1) p++;
      step();
    end
    nvec++;
    if (e != 0 || p != 8) begin
      nerr++;
      $display("FAIL shared_tap: %0d differ, %0d pulses want 8", e, p);
    end
  endtask

  task automatic test_ext();
    int e;
    clk_sel0 = 3'd0;
    clk_sel1 = 3'd7;
    repeat (5) step();
    t1_pin = 1'b1;
    e = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (timer1_clk !== (j == 3)) e++;
    end
    nvec++;
    if (e != 0) begin
      nerr++;
      $display("FAIL ext_rise_sel7: %0d bad cycles want 0", e);
    end
    t1_pin = 1'b0;
    e = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (timer1_clk !== 1'b0) e++;
    end
    nvec++;
    if (e != 0) begin
      nerr++;
      $display("FAIL ext_fall_sel7: %0d pulses want 0", e);
    end
    clk_sel1 = 3'd6;
    t1_pin = 1'b1;
    e = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (timer1_clk !== 1'b0) e++;
    end
    nvec++;
    if (e != 0) begin
      nerr++;
      $display("FAIL ext_rise_sel6: %0d pulses want 0", e);
    end
    t1_pin = 1'b0;
    e = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (timer1_clk !== (j == 3)) e++;
    end
    nvec++;
    if (e != 0) begin
      nerr++;
      $display("FAIL ext_fall_sel6: %0d bad cycles want 0", e);
    end
  endtask

  task automatic test_tstat();
    t0_pin = 1'b1;
    repeat (3) step();
    io_a  = STAT;
    io_re = 1'b1;
    step();
    io_re = 1'b0;
    nvec++;
    if (io_do !== 8'h01) begin
      nerr++;
      $display("FAIL tstat_t0: got %h want 01", io_do);
    end
    step();
    nvec++;
    if (io_do !== 8'h00) begin
      nerr++;
      $display("FAIL tstat_after: got %h want 00", io_do);
    end
    t0_pin = 1'b0;
    t1_pin = 1'b1;
    repeat (3) step();
    io_re = 1'b1;
    step();
    io_re = 1'b0;
    nvec++;
    if (io_do !== 8'h02) begin
      nerr++;
      $display("FAIL tstat_t1: got %h want 02", io_do);
    end
    t1_pin = 1'b0;
    io_a  = 6'h2A;
    io_re = 1'b1;
    step();
    io_re = 1'b0;
    nvec++;
    if (io_do !== 8'h00) begin
      nerr++;
      $display("FAIL read_other_addr: got %h want 00", io_do);
    end
    io_a  = STAT;
    io_di = 8'hFF;
    io_we = 1'b1;
    step();
    io_we = 1'b0;
    io_a  = BASE;
    io_re = 1'b1;
    step();
    io_re = 1'b0;
    nvec++;
    if (io_do !== 8'h00) begin
      nerr++;
      $display("FAIL tstat_write_ignored: got %h want 00", io_do);
    end
  endtask

  task automatic test_async_rst();
    int e0;
    int e1;
    clk_sel0 = 3'd1;
    clk_sel1 = 3'd2;
    t0_pin = 1'b1;
    repeat (4) step();
    psr_write(8'h01);
    repeat (6) step();
    io_a  = STAT;
    io_re = 1'b1;
    step();
    io_re = 1'b0;
    nvec++;
    if (timer1_clk !== 1'b1 || io_do !== 8'h01) begin
      nerr++;
      $display("FAIL pre_rst_state: t1=%b io_do=%h want 1/01", timer1_clk, io_do);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    nvec++;
    if (io_do !== 8'h00 || timer1_clk !== 1'b0 || timer0_clk !== 1'b1) begin
      nerr++;
      $display("FAIL async_rst: io_do=%h t1=%b t0=%b want 00/0/1", io_do, timer1_clk, timer0_clk);
    end
    clk_sel0 = 3'd7;
    step();
    nvec++;
    if (timer0_clk !== 1'b0) begin
      nerr++;
      $display("FAIL rst_sel7: got %b want 0", timer0_clk);
    end
    step();
    sys_rst = 1'b0;
    e0 = 0;
    e1 = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (timer0_clk !== (j == 3)) e0++;
      if (timer1_clk !== (j == 7)) e1++;
    end
    nvec++;
    if (e0 != 0) begin
      nerr++;
      $display("FAIL pin_high_thru_rst: %0d bad cycles want 0", e0);
    end
    nvec++;
    if (e1 != 0) begin
      nerr++;
      $display("FAIL post_rst_div8: %0d bad cycles want 0", e1);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    sys_rst = 1'b1;
    io_a = '0;
    io_we = 1'b0;
    io_re = 1'b0;
    io_di = '0;
    t0_pin = 1'b0;
    t1_pin = 1'b0;
    clk_sel0 = '0;
    clk_sel1 = '0;
    test_reset();
    test_div();
    test_psr_clear();
    test_tsm();
    test_back_to_back();
    test_ext();
    test_tstat();
    test_async_rst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
